i2c_slv_fsm: RTL and testbench
==============================

I2C_SLV_FSM -- requirements
Module: i2c_slv_fsm

Interface
REQ-001 The block SHALL have the parameter ADDR_SZ, default 7, giving the slave address width.
REQ-002 The block SHALL have the parameter DATA_SZ, default 8, giving the data byte width.
REQ-003 The block SHALL have the parameter SLV_ADDR, default 7'h68, giving the own slave address.
REQ-004 The block SHALL have the port CLK: input, 1 bit, system clock 50 MHz.
REQ-005 The block SHALL have the port RST: input, 1 bit, reset; it is asynchronous and active-high.
REQ-006 The block SHALL have the port I_SCL: input, 1 bit, I2C serial clock from the bus, asynchronous to CLK.
REQ-007 The block SHALL have the port I_SDA: input, 1 bit, I2C serial data from the bus, asynchronous to CLK.
REQ-008 The block SHALL have the port I_DATA_RD: input, DATA_SZ bits, byte to return to the master.
REQ-009 The block SHALL have the port O_SDA_OE: output, 1 bit; 1 pulls SDA low and 0 releases SDA.
REQ-010 The block SHALL have the port O_DATA_WR: output, DATA_SZ bits, last byte written by the master.
REQ-011 The block SHALL have the port O_WR_VLD: output, 1 bit, one-CLK strobe when O_DATA_WR is updated.
REQ-012 The block SHALL have the port O_RD_REQ: output, 1 bit, one-CLK request for the next I_DATA_RD byte.
REQ-013 The block SHALL have the port O_BUSY: output, 1 bit, high while addressed (ADDR_ACK through RD_ACK).
REQ-014 The block SHALL have the port O_STOP: output, 1 bit, one-CLK pulse on every detected STOP.

Function
REQ-015 I_SCL and I_SDA SHALL each pass through a 2-FF synchronizer (scl_s, sda_s) plus one delay FF; all edges SHALL be derived from the synchronized signals only.
REQ-016 START SHALL be detected as an sda_s falling edge while scl_s and its delayed copy are both 1.
REQ-017 STOP SHALL be detected as an sda_s rising edge under the same condition as START.
REQ-018 SDA SHALL be sampled on the CLK of the scl_s rising edge; O_SDA_OE SHALL change only on the CLK of the scl_s falling edge.
REQ-019 The FSM SHALL have one-hot states IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE.
REQ-020 IDLE SHALL move to ADDR on START, with the bit counter loaded to DATA_SZ-1.
REQ-021 ADDR SHALL shift in 8 bits MSB first; after the 8th rise it SHALL compare {addr[ADDR_SZ-1:0]} with SLV_ADDR and latch R/W.
REQ-022 On an address match, at the next SCL fall the FSM SHALL enter ADDR_ACK and set O_SDA_OE=1.
REQ-023 On an address mismatch the FSM SHALL enter IGNORE with O_SDA_OE=0; IGNORE SHALL be left only on START (to ADDR) or STOP (to IDLE).
REQ-024 ADDR_ACK with R/W=0 SHALL release OE at the ACK-ending fall and enter WR.
REQ-025 ADDR_ACK with R/W=1 SHALL pulse O_RD_REQ on the ACK rise; at the ACK-ending fall it SHALL capture I_DATA_RD into the tx shift register, drive OE=~MSB and enter RD.
REQ-026 WR SHALL shift in 8 bits; on the 8th rise it SHALL set O_DATA_WR to the byte and pulse O_WR_VLD for the same CLK; at the next fall it SHALL set OE=1 and enter WR_ACK.
REQ-027 Every written byte SHALL be ACKed.
REQ-028 WR_ACK SHALL release OE at the following fall and return to WR with the counter reloaded.
REQ-029 RD SHALL drive OE=~bit on each fall (MSB first); after the 8th bit's ending fall it SHALL set OE=0 and enter RD_ACK.
REQ-030 In RD_ACK, the master ACK (sda_s=0 on rise) SHALL pulse O_RD_REQ, and the next fall SHALL load I_DATA_RD and re-enter RD.
REQ-031 In RD_ACK, a master NACK (sda_s=1) SHALL send the FSM to IGNORE.
REQ-032 From any state, START SHALL force ADDR (repeated start), clear OE and reload the counter; this SHALL take priority over a coincident SCL edge.
REQ-033 From any state, STOP SHALL force IDLE, clear OE and pulse O_STOP.
REQ-034 An illegal state encoding SHALL go to IDLE with OE=0.
REQ-035 The bit counter SHALL be $clog2(DATA_SZ) wide and SHALL wrap from 0 to DATA_SZ-1 only at byte end.

Reset
REQ-036 RST=1 SHALL asynchronously force state IDLE, O_SDA_OE=0, O_DATA_WR=0, O_WR_VLD=0, O_RD_REQ=0, O_BUSY=0, O_STOP=0, and the synchronizers to 1.
REQ-037 A reset asserted mid-byte SHALL release SDA within the same CLK; after release the block SHALL wait for a new START.

Structure
REQ-038 The state encodings, ADDR_SZ/DATA_SZ defaults and the MPU-6050 address constant SHALL live in a shared i2c package used by both master and slave.
REQ-039 The sub-module i2c_sync_edge (2-FF synchronizer plus rise/fall detect, instantiated for SCL and SDA) SHALL be the only child.

Verification
REQ-040 The bench SHALL cover a write: START, 0xD0, 0xA5, STOP, which SHALL produce an ACK on both bytes, O_DATA_WR=0xA5 with a single O_WR_VLD pulse, and an O_STOP pulse.
REQ-041 The bench SHALL cover a read: START, 0xD1 with I_DATA_RD=0x3C, master NACK, STOP, which SHALL put 0,0,1,1,1,1,0,0 on SDA, produce one O_RD_REQ, and go to IGNORE then IDLE.
REQ-042 The bench SHALL cover a burst read: I_DATA_RD=0x11 then 0x22 with master ACK, which SHALL produce two O_RD_REQ pulses and both bytes serialized.
REQ-043 The bench SHALL cover an address mismatch: 0xA0 followed by 0x55, which SHALL never assert O_SDA_OE nor pulse O_WR_VLD.
REQ-044 The bench SHALL cover a repeated start: write 0xD0 and 0x75, then START and 0xD1, which SHALL produce O_DATA_WR=0x75, then ADDR_ACK then RD, with no O_STOP between them.
REQ-045 The bench SHALL cover reset mid-RD while OE=1: RST pulsed, which SHALL give OE=0 asynchronously, O_BUSY=0, and no ACK until the next START.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions for the master and slave controllers.
//   ADDR_SZ_DFLT / DATA_SZ_DFLT : default address and data widths
//   MPU6050_ADDR                : 7-bit bus address of the MPU-6050
//   slv_state_t                 : one-hot slave FSM state encoding
package i2c_pkg;

  localparam int unsigned ADDR_SZ_DFLT = 7;
  localparam int unsigned DATA_SZ_DFLT = 8;
  localparam logic [6:0]  MPU6050_ADDR = 7'h68;

  typedef enum logic [7:0] {
    ST_IDLE     = 8'b0000_0001,
    ST_ADDR     = 8'b0000_0010,
    ST_ADDR_ACK = 8'b0000_0100,
    ST_WR       = 8'b0000_1000,
    ST_WR_ACK   = 8'b0001_0000,
    ST_RD       = 8'b0010_0000,
    ST_RD_ACK   = 8'b0100_0000,
    ST_IGNORE   = 8'b1000_0000
  } slv_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer plus a delay flop with rise/fall detection.
//   CLK, RST  : system clock, async active-high reset (flops reset to 1)
//   I_D       : asynchronous bus line
//   O_S       : synchronized level
//   O_RISE_C  : one-CLK pulse on a synchronized rising edge
//   O_FALL_C  : one-CLK pulse on a synchronized falling edge
module i2c_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic I_D,
  output logic O_S,
  output logic O_RISE_C,
  output logic O_FALL_C
);

  logic meta;
  logic dly;

  // Idle I2C lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      meta <= 1'b1;
      O_S  <= 1'b1;
      dly  <= 1'b1;
    end else begin
      meta <= I_D;
      O_S  <= meta;
      dly  <= O_S;
    end
  end

  assign O_RISE_C = O_S & ~dly;
  assign O_FALL_C = ~O_S & dly;

endmodule

// File: rtl/i2c_slv_fsm.sv
// I2C slave byte engine: address match, write bytes out, read bytes in.
//   CLK, RST   : system clock, async active-high reset
//   I_SCL      : bus clock (asynchronous)
//   I_SDA      : bus data (asynchronous)
//   I_DATA_RD  : byte returned to the master, sampled when O_RD_REQ is served
//   O_SDA_OE   : 1 pulls SDA low, 0 releases it
//   O_DATA_WR  : last byte written by the master, O_WR_VLD strobes on update
//   O_RD_REQ   : one-CLK request for the next I_DATA_RD byte
//   O_BUSY     : high while this slave is addressed
//   O_STOP     : one-CLK pulse on every STOP
module i2c_slv_fsm
  import i2c_pkg::*;
#(
  parameter int unsigned        ADDR_SZ  = ADDR_SZ_DFLT,
  parameter int unsigned        DATA_SZ  = DATA_SZ_DFLT,
  parameter logic [ADDR_SZ-1:0] SLV_ADDR = ADDR_SZ'(MPU6050_ADDR)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               I_SCL,
  input  logic               I_SDA,
  input  logic [DATA_SZ-1:0] I_DATA_RD,
  output logic               O_SDA_OE,
  output logic [DATA_SZ-1:0] O_DATA_WR,
  output logic               O_WR_VLD,
  output logic               O_RD_REQ,
  output logic               O_BUSY,
  output logic               O_STOP
);

  localparam int unsigned      CNT_W   = $clog2(DATA_SZ);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_SZ - 1);

  logic scl_s, scl_rise, scl_fall;
  logic sda_s, sda_rise, sda_fall;
  logic scl_hi, start_c, stop_c;

  slv_state_t         state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               byte_end;
  logic               addr_hit;
  logic               rw;
  logic [DATA_SZ-2:0] rx_sr;
  logic [DATA_SZ-2:0] tx_sr;
  logic [DATA_SZ-1:0] rx_nxt;

  i2c_sync_edge u_scl (
    .CLK      (CLK),
    .RST      (RST),
    .I_D      (I_SCL),
    .O_S      (scl_s),
    .O_RISE_C (scl_rise),
    .O_FALL_C (scl_fall)
  );

  i2c_sync_edge u_sda (
    .CLK      (CLK),
    .RST      (RST),
    .I_D      (I_SDA),
    .O_S      (sda_s),
    .O_RISE_C (sda_rise),
    .O_FALL_C (sda_fall)
  );

  // scl_s high and not just risen is the same as scl_s and its delayed copy both high.
  assign scl_hi  = scl_s & ~scl_rise;
  assign start_c = sda_fall & scl_hi;
  assign stop_c  = sda_rise & scl_hi;
  assign rx_nxt  = {rx_sr, sda_s};

  // Slave FSM; START/STOP override any coincident SCL edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      O_SDA_OE  <= 1'b0;
      O_DATA_WR <= '0;
      O_WR_VLD  <= 1'b0;
      O_RD_REQ  <= 1'b0;
      O_BUSY    <= 1'b0;
      O_STOP    <= 1'b0;
      bit_cnt   <= CNT_MAX;
      byte_end  <= 1'b0;
      addr_hit  <= 1'b0;
      rw        <= 1'b0;
      rx_sr     <= '0;
      tx_sr     <= '0;
    end else begin
      O_WR_VLD <= 1'b0;
      O_RD_REQ <= 1'b0;
      O_STOP   <= 1'b0;
      if (start_c) begin
        state    <= ST_ADDR;
        O_SDA_OE <= 1'b0;
        O_BUSY   <= 1'b0;
        bit_cnt  <= CNT_MAX;
        byte_end <= 1'b0;
      end else if (stop_c) begin
        state    <= ST_IDLE;
        O_SDA_OE <= 1'b0;
        O_BUSY   <= 1'b0;
        O_STOP   <= 1'b1;
        byte_end <= 1'b0;
      end else begin
        case (state)
          ST_IDLE, ST_IGNORE: begin
          end
          ST_ADDR, ST_WR: begin
            if (scl_rise) begin
              rx_sr <= rx_nxt[DATA_SZ-2:0];
              if (bit_cnt == '0) begin
                bit_cnt  <= CNT_MAX;
                byte_end <= 1'b1;
                if (state == ST_ADDR) begin
                  addr_hit <= (rx_nxt[DATA_SZ-1 -: ADDR_SZ] == SLV_ADDR);
                  rw       <= rx_nxt[0];
                end else begin
                  O_DATA_WR <= rx_nxt;
                  O_WR_VLD  <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt - CNT_W'(1);
              end
            end else if (scl_fall && byte_end) begin
              byte_end <= 1'b0;
              if (state == ST_WR) begin
                O_SDA_OE <= 1'b1;
                state    <= ST_WR_ACK;
              end else if (addr_hit) begin
                O_SDA_OE <= 1'b1;
                O_BUSY   <= 1'b1;
                state    <= ST_ADDR_ACK;
              end else begin
                state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_rise) begin
              O_RD_REQ <= rw;
            end else if (scl_fall) begin
              bit_cnt <= CNT_MAX;
              if (rw) begin
                tx_sr    <= I_DATA_RD[DATA_SZ-2:0];
                O_SDA_OE <= ~I_DATA_RD[DATA_SZ-1];
                state    <= ST_RD;
              end else begin
                O_SDA_OE <= 1'b0;
                state    <= ST_WR;
              end
            end
          end
          ST_WR_ACK: begin
            if (scl_fall) begin
              O_SDA_OE <= 1'b0;
              bit_cnt  <= CNT_MAX;
              state    <= ST_WR;
            end
          end
          ST_RD: begin
            if (scl_rise) begin
              if (bit_cnt == '0) begin
                bit_cnt  <= CNT_MAX;
                byte_end <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt - CNT_W'(1);
              end
            end else if (scl_fall) begin
              if (byte_end) begin
                byte_end <= 1'b0;
                O_SDA_OE <= 1'b0;
                state    <= ST_RD_ACK;
              end else begin
                // tx_sr holds the bits still to send, next one at the top.
                O_SDA_OE <= ~tx_sr[DATA_SZ-2];
                tx_sr    <= {tx_sr[DATA_SZ-3:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            // A fall here is only reachable after an ACKed rise; NACK leaves on the rise.
            if (scl_rise) begin
              if (!sda_s) begin
                O_RD_REQ <= 1'b1;
              end else begin
                O_BUSY <= 1'b0;
                state  <= ST_IGNORE;
              end
            end else if (scl_fall) begin
              tx_sr    <= I_DATA_RD[DATA_SZ-2:0];
              O_SDA_OE <= ~I_DATA_RD[DATA_SZ-1];
              bit_cnt  <= CNT_MAX;
              state    <= ST_RD;
            end
          end
          default: begin
            state    <= ST_IDLE;
            O_SDA_OE <= 1'b0;
            O_BUSY   <= 1'b0;
            byte_end <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slv_fsm.sv
// Directed bench for i2c_slv_fsm: table of single-byte transactions plus
// burst read, repeated start and mid-read reset sequences.
module tb_i2c_slv_fsm;
  import i2c_pkg::*;

  localparam int Q = 8;  // CLK cycles per quarter SCL period

  logic       CLK = 1'b0;
  logic       RST;
  logic       scl;
  logic       msda;
  logic [7:0] I_DATA_RD;
  logic       O_SDA_OE;
  logic [7:0] O_DATA_WR;
  logic       O_WR_VLD;
  logic       O_RD_REQ;
  logic       O_BUSY;
  logic       O_STOP;
  logic       sda_bus;

  // Open-drain bus: master and slave both pull low.
  assign sda_bus = msda & ~O_SDA_OE;

  always #10 CLK = ~CLK;

  i2c_slv_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .I_SCL     (scl),
    .I_SDA     (sda_bus),
    .I_DATA_RD (I_DATA_RD),
    .O_SDA_OE  (O_SDA_OE),
    .O_DATA_WR (O_DATA_WR),
    .O_WR_VLD  (O_WR_VLD),
    .O_RD_REQ  (O_RD_REQ),
    .O_BUSY    (O_BUSY),
    .O_STOP    (O_STOP)
  );

  int checks = 0;
  int errors = 0;
  int n_wr = 0, n_rd = 0, n_stop = 0, n_oe = 0;

  always @(negedge CLK) begin
    if (O_WR_VLD) n_wr++;
    if (O_RD_REQ) n_rd++;
    if (O_STOP)   n_stop++;
    if (O_SDA_OE) n_oe++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wq();
    repeat (Q) @(negedge CLK);
  endtask

  task automatic i2c_start();
    msda = 1'b1; wq();
    scl  = 1'b1; wq();
    msda = 1'b0; wq();
    scl  = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    msda = 1'b0; wq();
    scl  = 1'b1; wq();
    msda = 1'b1; wq();
  endtask

  task automatic bit_xfer(input logic b, output logic s);
    msda = b;    wq();
    scl  = 1'b1; wq();
    s = sda_bus; wq();
    scl  = 1'b0; wq();
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], s);
    bit_xfer(1'b1, ack);
  endtask

  task automatic rd_bits(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      d[i] = s;
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rd_data;
    logic       exp_ack;   // bus level in the ACK slots, 0 = ACK
    logic [7:0] exp_byte;  // read: serialized byte, write: O_DATA_WR after
    int         exp_wr;
    int         exp_rd;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic       a, a2, s;
    logic [7:0] d, d2;
    int         w0, r0, s0, o0;

    vecs[0] = '{8'hD0, 8'hA5, 8'h00, 1'b0, 8'hA5, 1, 0};
    vecs[1] = '{8'hD1, 8'h00, 8'h3C, 1'b0, 8'h3C, 0, 1};
    vecs[2] = '{8'hA0, 8'h55, 8'h00, 1'b1, 8'hA5, 0, 0};
    vecs[3] = '{8'hD0, 8'h00, 8'h00, 1'b0, 8'h00, 1, 0};
    vecs[4] = '{8'hD1, 8'h00, 8'hFF, 1'b0, 8'hFF, 0, 1};
    vecs[5] = '{8'hD1, 8'h00, 8'h80, 1'b0, 8'h80, 0, 1};
    vecs[6] = '{8'hD0, 8'hFF, 8'h00, 1'b0, 8'hFF, 1, 0};
    vecs[7] = '{8'hD2, 8'h12, 8'h00, 1'b1, 8'hFF, 0, 0};

    RST = 1'b1; scl = 1'b1; msda = 1'b1; I_DATA_RD = 8'h00;
    repeat (4) @(negedge CLK);
    chk("rst_oe",    32'(O_SDA_OE),  32'(0));
    chk("rst_dwr",   32'(O_DATA_WR), 32'(0));
    chk("rst_vld",   32'(O_WR_VLD),  32'(0));
    chk("rst_req",   32'(O_RD_REQ),  32'(0));
    chk("rst_busy",  32'(O_BUSY),    32'(0));
    chk("rst_stop",  32'(O_STOP),    32'(0));
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    RST = 1'b0;
    wq();

    for (int v = 0; v < 8; v++) begin
      w0 = n_wr; r0 = n_rd; s0 = n_stop; o0 = n_oe;
      I_DATA_RD = vecs[v].rd_data;
      i2c_start();
      wr_byte(vecs[v].addr, a);
      chk($sformatf("v%0d_addr_ack", v), 32'(a), 32'(vecs[v].exp_ack));
      if (vecs[v].addr[0] && !vecs[v].exp_ack) begin
        rd_bits(d);
        bit_xfer(1'b1, s);
        chk($sformatf("v%0d_rd_byte", v), 32'(d), 32'(vecs[v].exp_byte));
        chk($sformatf("v%0d_nack_state", v), 32'(dut.state), 32'(ST_IGNORE));
      end else begin
        wr_byte(vecs[v].data, a2);
        chk($sformatf("v%0d_data_ack", v), 32'(a2), 32'(vecs[v].exp_ack));
        chk($sformatf("v%0d_data_wr", v), 32'(O_DATA_WR), 32'(vecs[v].exp_byte));
      end
      i2c_stop();
      wq();
      chk($sformatf("v%0d_wr_vld", v), 32'(n_wr - w0), 32'(vecs[v].exp_wr));
      chk($sformatf("v%0d_rd_req", v), 32'(n_rd - r0), 32'(vecs[v].exp_rd));
      chk($sformatf("v%0d_stop", v), 32'(n_stop - s0), 32'(1));
      chk($sformatf("v%0d_busy", v), 32'(O_BUSY), 32'(0));
      chk($sformatf("v%0d_idle", v), 32'(dut.state), 32'(ST_IDLE));
      if (vecs[v].exp_ack) chk($sformatf("v%0d_oe_quiet", v), 32'(n_oe - o0), 32'(0));
    end

    // Burst read 0x11 then 0x22 with master ACK between
    r0 = n_rd;
    I_DATA_RD = 8'h11;
    i2c_start();
    wr_byte(8'hD1, a);
    chk("burst_addr_ack", 32'(a), 32'(0));
    rd_bits(d);
    I_DATA_RD = 8'h22;
    bit_xfer(1'b0, s);
    chk("burst_state_rd", 32'(dut.state), 32'(ST_RD));
    rd_bits(d2);
    bit_xfer(1'b1, s);
    i2c_stop();
    wq();
    chk("burst_byte0", 32'(d),  32'(8'h11));
    chk("burst_byte1", 32'(d2), 32'(8'h22));
    chk("burst_rd_req", 32'(n_rd - r0), 32'(2));

    // Repeated start: write 0x75 then read without STOP
    s0 = n_stop;
    I_DATA_RD = 8'h5A;
    i2c_start();
    wr_byte(8'hD0, a);
    wr_byte(8'h75, a2);
    chk("rs_data_ack", 32'(a2), 32'(0));
    chk("rs_data_wr", 32'(O_DATA_WR), 32'(8'h75));
    i2c_start();
    chk("rs_state_addr", 32'(dut.state), 32'(ST_ADDR));
    wr_byte(8'hD1, a);
    chk("rs_addr_ack", 32'(a), 32'(0));
    chk("rs_state_rd", 32'(dut.state), 32'(ST_RD));
    chk("rs_busy", 32'(O_BUSY), 32'(1));
    rd_bits(d);
    bit_xfer(1'b1, s);
    chk("rs_rd_byte", 32'(d), 32'(8'h5A));
    chk("rs_no_stop", 32'(n_stop - s0), 32'(0));
    i2c_stop();
    wq();
    chk("rs_stop", 32'(n_stop - s0), 32'(1));

    // Reset while the slave is driving a 0 in RD
    I_DATA_RD = 8'h00;
    i2c_start();
    wr_byte(8'hD1, a);
    chk("mr_state_rd", 32'(dut.state), 32'(ST_RD));
    chk("mr_oe_before", 32'(O_SDA_OE), 32'(1));
    @(negedge CLK);
    #3 RST = 1'b1;
    #1;
    chk("mr_oe_async", 32'(O_SDA_OE), 32'(0));
    chk("mr_busy", 32'(O_BUSY), 32'(0));
    chk("mr_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge CLK);
    RST = 1'b0;
    o0 = n_oe;
    rd_bits(d);
    bit_xfer(1'b1, s);
    chk("mr_bus_released", 32'(d), 32'(8'hFF));
    chk("mr_oe_quiet", 32'(n_oe - o0), 32'(0));
    chk("mr_dwr_cleared", 32'(O_DATA_WR), 32'(0));
    i2c_stop();
    i2c_start();
    wr_byte(8'hD0, a);
    chk("mr_ack_after_start", 32'(a), 32'(0));
    wr_byte(8'h3C, a2);
    i2c_stop();
    wq();
    chk("mr_data_wr", 32'(O_DATA_WR), 32'(8'h3C));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
